execute_stage: RTL and testbench

//  MIPS pipeline EX stage between decode/register-read and memory access.

---
 rtl/execute_stage_pkg.sv | 45 ++++
 rtl/execute_stage_alu.sv | 57 +++++
 rtl/execute_stage.sv | 87 ++++++++
 tb/tb_execute_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the EX stage: field widths plus the opcode and funct
// values the ALU decodes.
package execute_stage_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ADDIU = 6'b001001,
    OP_SLTI  = 6'b001010,
    OP_SLTIU = 6'b001011,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [FUNCT_WIDTH-1:0] {
    FN_SLL  = 6'b000000,
    FN_SRL  = 6'b000010,
    FN_SRA  = 6'b000011,
    FN_ADD  = 6'b100000,
    FN_ADDU = 6'b100001,
    FN_SUB  = 6'b100010,
    FN_SUBU = 6'b100011,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110,
    FN_NOR  = 6'b100111,
    FN_SLT  = 6'b101010,
    FN_SLTU = 6'b101011
  } funct_e;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic imm_zero_ext(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the EX stage.
//   a, b    : operands (b is already muxed between rt and extended imm)
//   shamt   : shift amount for SLL/SRL/SRA (shifts apply to b = rt)
//   opcode  : instruction opcode; RTYPE defers to funct
//   funct   : R-type function field
//   result  : ALU output, 0 for unknown opcode/funct
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0]       a,
  input  logic [DWIDTH-1:0]       b,
  input  logic [4:0]              shamt,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  output logic [DWIDTH-1:0]       result
);

  logic [DWIDTH-1:0] slt_s, slt_u;

  assign slt_s = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
  assign slt_u = {{(DWIDTH-1){1'b0}}, (a < b)};

  always_comb begin
    result = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: result = a + b;
          FN_SUB, FN_SUBU: result = a - b;
          FN_AND:          result = a & b;
          FN_OR:           result = a | b;
          FN_XOR:          result = a ^ b;
          FN_NOR:          result = ~(a | b);
          FN_SLT:          result = slt_s;
          FN_SLTU:         result = slt_u;
          FN_SLL:          result = b << shamt;
          FN_SRL:          result = b >> shamt;
          FN_SRA:          result = $unsigned($signed(b) >>> shamt);
          default:         result = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result = a + b;
      OP_SLTI:                         result = slt_s;
      OP_SLTIU:                        result = slt_u;
      OP_ANDI:                         result = a & b;
      OP_ORI:                          result = a | b;
      OP_XORI:                         result = a ^ b;
      // b holds ext(imm); upper extension bits fall off the top.
      OP_LUI:                          result = b << 16;
      OP_BEQ, OP_BNE:                  result = a - b;
      default:                         result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand-B select, ALU, branch target and taken decision,
// all registered into the EX/MEM boundary (one cycle latency).
//   es_clk, es_rst           : clock, synchronous active-high reset
//   es_i_ce                  : valid from decode
//   es_i_alu_src/branch      : B select, conditional-branch flag
//   es_i_pc/imm/alu_op/funct : PC+4, immediate, opcode, funct
//   es_i_data_rs/rt          : register operands
//   es_o_*                   : registered results to MEM
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int IMM_WIDTH = 16,
  parameter int PC_WIDTH  = 32
) (
  input  logic                    es_clk,
  input  logic                    es_rst,
  input  logic                    es_i_ce,
  input  logic                    es_i_alu_src,
  input  logic                    es_i_branch,
  input  logic [PC_WIDTH-1:0]     es_i_pc,
  input  logic [IMM_WIDTH-1:0]    es_i_imm,
  input  logic [OPCODE_WIDTH-1:0] es_i_alu_op,
  input  logic [FUNCT_WIDTH-1:0]  es_i_alu_funct,
  input  logic [DWIDTH-1:0]       es_i_data_rs,
  input  logic [DWIDTH-1:0]       es_i_data_rt,
  output logic [DWIDTH-1:0]       es_o_alu_value,
  output logic [PC_WIDTH-1:0]     es_o_alu_pc,
  output logic [OPCODE_WIDTH-1:0] es_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  es_o_funct,
  output logic                    es_o_zero,
  output logic                    es_o_ce,
  output logic                    es_o_change_pc
);

  logic                  is_beq, is_bne;
  logic [DWIDTH-1:0]     imm_ext, op_b, result;
  logic [PC_WIDTH-1:0]   imm_pc, pc_target;
  logic                  zero, taken;

  assign is_beq = (es_i_alu_op == OP_BEQ);
  assign is_bne = (es_i_alu_op == OP_BNE);

  assign imm_ext = imm_zero_ext(es_i_alu_op)
                 ? {{(DWIDTH-IMM_WIDTH){1'b0}}, es_i_imm}
                 : {{(DWIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};

  // Branch compares always use rt, whatever alu_src says.
  assign op_b = (es_i_alu_src && !is_beq && !is_bne) ? imm_ext : es_i_data_rt;

  execute_stage_alu #(.DWIDTH(DWIDTH)) u_alu (
    .a      (es_i_data_rs),
    .b      (op_b),
    .shamt  (es_i_imm[10:6]),
    .opcode (es_i_alu_op),
    .funct  (es_i_alu_funct),
    .result (result)
  );

  assign zero      = (result == '0);
  assign imm_pc    = {{(PC_WIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
  assign pc_target = es_i_pc + (imm_pc << 2);
  assign taken     = es_i_branch & ((is_beq & zero) | (is_bne & ~zero));

  always_ff @(posedge es_clk) begin
    if (es_rst) begin
      es_o_alu_value <= '0;
      es_o_alu_pc    <= '0;
      es_o_opcode    <= '0;
      es_o_funct     <= '0;
      es_o_zero      <= 1'b0;
      es_o_ce        <= 1'b0;
      es_o_change_pc <= 1'b0;
    end else begin
      es_o_ce        <= es_i_ce;
      es_o_change_pc <= es_i_ce & taken;  // single-cycle strobe
      if (es_i_ce) begin
        es_o_alu_value <= result;
        es_o_alu_pc    <= pc_target;
        es_o_opcode    <= es_i_alu_op;
        es_o_funct     <= es_i_alu_funct;
        es_o_zero      <= zero;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        es_clk = 1'b0;
  logic        es_rst;
  logic        es_i_ce, es_i_alu_src, es_i_branch;
  logic [31:0] es_i_pc;
  logic [15:0] es_i_imm;
  logic [5:0]  es_i_alu_op, es_i_alu_funct;
  logic [31:0] es_i_data_rs, es_i_data_rt;
  logic [31:0] es_o_alu_value, es_o_alu_pc;
  logic [5:0]  es_o_opcode, es_o_funct;
  logic        es_o_zero, es_o_ce, es_o_change_pc;

  int n_chk = 0;
  int n_fail = 0;

  execute_stage dut (
    .es_clk(es_clk), .es_rst(es_rst), .es_i_ce(es_i_ce),
    .es_i_alu_src(es_i_alu_src), .es_i_branch(es_i_branch),
    .es_i_pc(es_i_pc), .es_i_imm(es_i_imm), .es_i_alu_op(es_i_alu_op),
    .es_i_alu_funct(es_i_alu_funct), .es_i_data_rs(es_i_data_rs),
    .es_i_data_rt(es_i_data_rt), .es_o_alu_value(es_o_alu_value),
    .es_o_alu_pc(es_o_alu_pc), .es_o_opcode(es_o_opcode),
    .es_o_funct(es_o_funct), .es_o_zero(es_o_zero), .es_o_ce(es_o_ce),
    .es_o_change_pc(es_o_change_pc)
  );

  always #5 es_clk = ~es_clk;

  task automatic drive(input logic ce, input logic src, input logic br,
                       input logic [31:0] pc, input logic [15:0] imm,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    es_i_ce = ce; es_i_alu_src = src; es_i_branch = br; es_i_pc = pc;
    es_i_imm = imm; es_i_alu_op = op; es_i_alu_funct = fn;
    es_i_data_rs = rs; es_i_data_rt = rt;
  endtask

  task automatic step();
    @(posedge es_clk);
    #1;
  endtask

  task automatic test_reset();
    es_rst = 1'b1;
    drive(1, 1, 1, 32'h40, 16'h0003, 6'b000100, 6'b100101, 5, 5);
    step(); step();
    n_chk++;
    if ({es_o_alu_value, es_o_alu_pc, es_o_opcode, es_o_funct,
         es_o_zero, es_o_ce, es_o_change_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset: alu=%h pc=%h op=%b fn=%b z=%b ce=%b chg=%b, required all 0",
               es_o_alu_value, es_o_alu_pc, es_o_opcode, es_o_funct,
               es_o_zero, es_o_ce, es_o_change_pc);
    end
    es_rst = 1'b0;
  endtask

  task automatic test_or();
    drive(1, 0, 0, 0, 0, 6'b000000, 6'b100101, 5, 4);
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_zero, es_o_change_pc, es_o_ce, es_o_funct, es_o_opcode}
        !== {32'd5, 1'b0, 1'b0, 1'b1, 6'b100101, 6'b000000}) begin
      n_fail++;
      $display("FAIL or: alu=%0d z=%b chg=%b ce=%b fn=%b op=%b, required 5 0 0 1 100101 000000",
               es_o_alu_value, es_o_zero, es_o_change_pc, es_o_ce, es_o_funct, es_o_opcode);
    end
  endtask

  task automatic test_sub();
    drive(1, 0, 0, 0, 0, 6'b000000, 6'b100010, 5, 4);
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_zero} !== {32'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_5_4: alu=%0d z=%b, required 1 0", es_o_alu_value, es_o_zero);
    end
    drive(1, 0, 0, 0, 0, 6'b000000, 6'b100010, 5, 5);
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_zero} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_5_5: alu=%0d z=%b, required 0 1", es_o_alu_value, es_o_zero);
    end
  endtask

  task automatic test_branch();
    drive(1, 0, 1, 32'd10, 16'd10, 6'b000100, 6'b000000, 5, 5);
    step();
    n_chk++;
    if ({es_o_zero, es_o_alu_pc, es_o_change_pc} !== {1'b1, 32'd50, 1'b1}) begin
      n_fail++;
      $display("FAIL beq_taken: z=%b pc=%0d chg=%b, required 1 50 1",
               es_o_zero, es_o_alu_pc, es_o_change_pc);
    end
    drive(1, 0, 1, 32'd10, 16'd10, 6'b000100, 6'b000000, 5, 4);
    step();
    n_chk++;
    if ({es_o_zero, es_o_change_pc} !== 2'b00) begin
      n_fail++;
      $display("FAIL beq_not_taken: z=%b chg=%b, required 0 0", es_o_zero, es_o_change_pc);
    end
    // Negative offset, and BNE taken.
    drive(1, 0, 1, 32'd100, 16'hFFFE, 6'b000101, 6'b000000, 5, 4);
    step();
    n_chk++;
    if ({es_o_change_pc, es_o_alu_pc} !== {1'b1, 32'd92}) begin
      n_fail++;
      $display("FAIL bne_taken: chg=%b pc=%0d, required 1 92", es_o_change_pc, es_o_alu_pc);
    end
    // BEQ equal but branch flag low -> no redirect.
    drive(1, 0, 0, 32'd10, 16'd10, 6'b000100, 6'b000000, 7, 7);
    step();
    n_chk++;
    if (es_o_change_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_no_branch_flag: chg=%b, required 0", es_o_change_pc);
    end
  endtask

  task automatic test_itype();
    drive(1, 1, 0, 0, 16'hFFFF, 6'b001000, 6'b000000, 5, 32'hDEAD);
    step();
    n_chk++;
    if (es_o_alu_value !== 32'd4) begin
      n_fail++;
      $display("FAIL addi: alu=%h, required 00000004", es_o_alu_value);
    end
    drive(1, 1, 0, 0, 16'hFFFF, 6'b001101, 6'b000000, 0, 0);
    step();
    n_chk++;
    if (es_o_alu_value !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL ori: alu=%h, required 0000ffff", es_o_alu_value);
    end
    drive(1, 1, 0, 0, 16'h1234, 6'b001111, 6'b000000, 0, 0);
    step();
    n_chk++;
    if (es_o_alu_value !== 32'h12340000) begin
      n_fail++;
      $display("FAIL lui: alu=%h, required 12340000", es_o_alu_value);
    end
  endtask

  task automatic test_rtype_misc();
    drive(1, 0, 0, 0, 0, 6'b000000, 6'b101010, 32'hFFFFFFFF, 1);
    step();
    n_chk++;
    if (es_o_alu_value !== 32'd1) begin
      n_fail++;
      $display("FAIL slt: alu=%h, required 00000001", es_o_alu_value);
    end
    drive(1, 0, 0, 0, 0, 6'b000000, 6'b101011, 32'hFFFFFFFF, 1);
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_zero} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sltu: alu=%h z=%b, required 00000000 1", es_o_alu_value, es_o_zero);
    end
    // shamt = imm[10:6] = 4
    drive(1, 0, 0, 0, 16'h0100, 6'b000000, 6'b000011, 0, 32'h80000000);
    step();
    n_chk++;
    if (es_o_alu_value !== 32'hF8000000) begin
      n_fail++;
      $display("FAIL sra: alu=%h, required f8000000", es_o_alu_value);
    end
    drive(1, 0, 0, 0, 0, 6'b000000, 6'b100111, 32'h0F0F0000, 32'h000000F0);
    step();
    n_chk++;
    if (es_o_alu_value !== 32'hF0F0FF0F) begin
      n_fail++;
      $display("FAIL nor: alu=%h, required f0f0ff0f", es_o_alu_value);
    end
    drive(1, 0, 0, 0, 0, 6'b111111, 6'b100000, 3, 4);
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_zero} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL unknown_op: alu=%h z=%b, required 00000000 1", es_o_alu_value, es_o_zero);
    end
  endtask

  task automatic test_hold();
    drive(1, 0, 1, 32'd10, 16'd10, 6'b000100, 6'b000000, 5, 5);
    step();
    drive(0, 0, 1, 32'd200, 16'd1, 6'b000100, 6'b000000, 9, 9);
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_alu_pc, es_o_zero, es_o_opcode, es_o_ce, es_o_change_pc}
        !== {32'd0, 32'd50, 1'b1, 6'b000100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ce_hold: alu=%0d pc=%0d z=%b op=%b ce=%b chg=%b, required 0 50 1 000100 0 0",
               es_o_alu_value, es_o_alu_pc, es_o_zero, es_o_opcode, es_o_ce, es_o_change_pc);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 32'd10, 16'd10, 6'b000101, 6'b100101, 5, 4);
    step();
    es_rst = 1'b1;
    step();
    n_chk++;
    if ({es_o_alu_value, es_o_alu_pc, es_o_opcode, es_o_funct,
         es_o_zero, es_o_ce, es_o_change_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: alu=%h pc=%h op=%b fn=%b z=%b ce=%b chg=%b, required all 0",
               es_o_alu_value, es_o_alu_pc, es_o_opcode, es_o_funct,
               es_o_zero, es_o_ce, es_o_change_pc);
    end
    es_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_or();
    test_sub();
    test_branch();
    test_itype();
    test_rtype_misc();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
